// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back arbiter for the 32x64-bit register file. The ALU result path and
// the data-memory load path each push {rd, data} into a private FIFO over a
// valid/ready handshake. Each cycle a round-robin arbiter pops at most one FIFO
// head into the registered register-file write port.
//
// Optional feature macro: REGFILE_WB_PENDING_EN
//   defined   -> Pending1/Pending2 flag in-flight writes to ReadReg1/ReadReg2
//   undefined -> Pending1/Pending2 tied to 0, compare logic omitted
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   reset                synchronous active-low reset
//   alu_valid/alu_ready  ALU write-back handshake
//   alu_rd/alu_data      ALU destination register / result
//   mem_valid/mem_ready  load write-back handshake
//   mem_rd/mem_data      load destination register / data
//   WriteReg             register file write enable (registered)
//   RegWrite             register file write index (registered)
//   WriteData            register file write data (registered)
//   ReadReg1/ReadReg2    decode-stage source indices for the pending check
//   Pending1/Pending2    a write to ReadReg1/ReadReg2 is still in flight
//   idle                 both FIFOs empty and WriteReg=0
// -----------------------------------------------------------------------------

// Per-requester FIFO of {rd, data}. DEPTH must be a power of two >= 2, so the
// pointers wrap naturally at PTR_W bits.
module regfile_wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] cmp1,
    input  logic [ADDR_W-1:0] cmp2,
    output logic              hit1,
    output logic              hit2
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;

    // Ready depends only on occupancy: a full FIFO refuses even while popping.
    assign push_ready = (count_r != FULL_CNT);
    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign head_rd    = rd_mem_r[rd_ptr_r];
    assign head_data  = data_mem_r[rd_ptr_r];
    assign push_s     = push_valid && push_ready;
    assign pop_s      = pop && head_valid;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= push_rd;
            data_mem_r[wr_ptr_r] <= push_data;
        end
    end

`ifdef REGFILE_WB_PENDING_EN
    logic [DEPTH-1:0] live_s;
    logic [DEPTH-1:0] hit1_vec_s;
    logic [DEPTH-1:0] hit2_vec_s;

    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
        assign live_s[i]     = ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r);
        assign hit1_vec_s[i] = live_s[i] && (rd_mem_r[i] == cmp1);
        assign hit2_vec_s[i] = live_s[i] && (rd_mem_r[i] == cmp2);
    end

    assign hit1 = |hit1_vec_s;
    assign hit2 = |hit2_vec_s;
`else
    logic unused_cmp_s;

    assign unused_cmp_s = ^{cmp1, cmp2};
    assign hit1         = 1'b0;
    assign hit2         = 1'b0;
`endif
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              WriteReg,
    output logic [ADDR_W-1:0] RegWrite,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              Pending1,
    output logic              Pending2,
    output logic              idle
);
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic              alu_head_valid_s;
    logic [ADDR_W-1:0] alu_head_rd_s;
    logic [DATA_W-1:0] alu_head_data_s;
    logic              alu_hit1_s;
    logic              alu_hit2_s;
    logic              mem_head_valid_s;
    logic [ADDR_W-1:0] mem_head_rd_s;
    logic [DATA_W-1:0] mem_head_data_s;
    logic              mem_hit1_s;
    logic              mem_hit2_s;

    logic              grant_alu_s;
    logic              grant_mem_s;
    logic              grant_any_s;
    logic [ADDR_W-1:0] grant_rd_s;
    logic [DATA_W-1:0] grant_data_s;

    logic              last_grant_r;
    logic              write_reg_r;
    logic [ADDR_W-1:0] reg_write_r;
    logic [DATA_W-1:0] write_data_r;

    regfile_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_alu_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (alu_valid),
        .push_ready (alu_ready),
        .push_rd    (alu_rd),
        .push_data  (alu_data),
        .pop        (grant_alu_s),
        .head_valid (alu_head_valid_s),
        .head_rd    (alu_head_rd_s),
        .head_data  (alu_head_data_s),
        .cmp1       (ReadReg1),
        .cmp2       (ReadReg2),
        .hit1       (alu_hit1_s),
        .hit2       (alu_hit2_s)
    );

    regfile_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (mem_valid),
        .push_ready (mem_ready),
        .push_rd    (mem_rd),
        .push_data  (mem_data),
        .pop        (grant_mem_s),
        .head_valid (mem_head_valid_s),
        .head_rd    (mem_head_rd_s),
        .head_data  (mem_head_data_s),
        .cmp1       (ReadReg1),
        .cmp2       (ReadReg2),
        .hit1       (mem_hit1_s),
        .hit2       (mem_hit2_s)
    );

    // Round-robin grant: a lone requester wins, a tie goes to whoever lost last.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        case ({alu_head_valid_s, mem_head_valid_s})
            2'b10: grant_alu_s = 1'b1;
            2'b01: grant_mem_s = 1'b1;
            2'b11: begin
                if (last_grant_r == GRANT_MEM) begin
                    grant_alu_s = 1'b1;
                end else begin
                    grant_mem_s = 1'b1;
                end
            end
            default: begin
                grant_alu_s = 1'b0;
                grant_mem_s = 1'b0;
            end
        endcase
    end

    assign grant_any_s  = grant_alu_s || grant_mem_s;
    assign grant_rd_s   = grant_mem_s ? mem_head_rd_s   : alu_head_rd_s;
    assign grant_data_s = grant_mem_s ? mem_head_data_s : alu_head_data_s;

    // Registered write port and round-robin history. Writes to x0 are drained
    // and still count as a grant, but never raise the write enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_r <= GRANT_MEM;
            write_reg_r  <= 1'b0;
            reg_write_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else if (grant_any_s) begin
            last_grant_r <= grant_mem_s ? GRANT_MEM : GRANT_ALU;
            write_reg_r  <= (grant_rd_s != {ADDR_W{1'b0}});
            reg_write_r  <= grant_rd_s;
            write_data_r <= grant_data_s;
        end else begin
            write_reg_r  <= 1'b0;
        end
    end

    assign WriteReg  = write_reg_r;
    assign RegWrite  = reg_write_r;
    assign WriteData = write_data_r;
    assign idle      = !alu_head_valid_s && !mem_head_valid_s && !write_reg_r;

`ifdef REGFILE_WB_PENDING_EN
    // A source is pending if any queued entry or the live output targets it;
    // x0 is never pending because it is never written.
    assign Pending1 = (ReadReg1 != {ADDR_W{1'b0}}) &&
                      (alu_hit1_s || mem_hit1_s ||
                       (write_reg_r && (reg_write_r == ReadReg1)));
    assign Pending2 = (ReadReg2 != {ADDR_W{1'b0}}) &&
                      (alu_hit2_s || mem_hit2_s ||
                       (write_reg_r && (reg_write_r == ReadReg2)));
`else
    logic unused_hit_s;

    assign unused_hit_s = ^{alu_hit1_s, alu_hit2_s, mem_hit1_s, mem_hit2_s};
    assign Pending1     = 1'b0;
    assign Pending2     = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DEPTH=2 defaults).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        WriteReg;
    logic [4:0]  RegWrite;
    logic [63:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        Pending1;
    logic        Pending2;
    logic        idle;

    int vectors     = 0;
    int miscompares = 0;
    logic pend_on;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .WriteReg  (WriteReg),
        .RegWrite  (RegWrite),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .Pending1  (Pending1),
        .Pending2  (Pending2),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [63:0] d);
        chk({tag, ".we"}, {63'd0, WriteReg}, {63'd0, we});
        chk({tag, ".rd"}, {59'd0, RegWrite}, {59'd0, rd});
        chk({tag, ".data"}, WriteData, d);
    endtask

    initial begin
`ifdef REGFILE_WB_PENDING_EN
        pend_on = 1'b1;
`else
        pend_on = 1'b0;
`endif
        reset = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        step(); step();
        reset = 1'b1;

        // Reset state
        chk_wr("rst", 1'b0, 5'd0, 64'd0);
        chk("rst.alu_ready", {63'd0, alu_ready}, 64'd1);
        chk("rst.mem_ready", {63'd0, mem_ready}, 64'd1);
        chk("rst.idle", {63'd0, idle}, 64'd1);
        chk("rst.pend1", {63'd0, Pending1}, 64'd0);
        chk("rst.pend2", {63'd0, Pending2}, 64'd0);

        // Single ALU push: write visible one cycle after acceptance
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAA;
        step();
        alu_valid = 1'b0;
        chk("t1.e0.we", {63'd0, WriteReg}, 64'd0);
        chk("t1.e0.idle", {63'd0, idle}, 64'd0);
        step();
        chk_wr("t1.e1", 1'b1, 5'd5, 64'hAA);
        chk("t1.e1.idle", {63'd0, idle}, 64'd0);
        step();
        chk_wr("t1.e2", 1'b0, 5'd5, 64'hAA);
        chk("t1.e2.idle", {63'd0, idle}, 64'd1);

        // ALU fill / backpressure (last grant = ALU, so MEM wins first tie)
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h61;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 64'h81;
        step();
        chk("t3.g0.we", {63'd0, WriteReg}, 64'd0);
        chk("t3.g0.alu_ready", {63'd0, alu_ready}, 64'd1);
        alu_rd = 5'd9; alu_data = 64'h62;
        mem_rd = 5'd11; mem_data = 64'h82;
        step();
        chk_wr("t3.g1", 1'b1, 5'd8, 64'h81);
        chk("t3.g1.alu_ready", {63'd0, alu_ready}, 64'd0);
        chk("t3.g1.mem_ready", {63'd0, mem_ready}, 64'd1);
        alu_rd = 5'd10; alu_data = 64'h63;
        mem_valid = 1'b0;
        step();
        chk_wr("t3.g2", 1'b1, 5'd6, 64'h61);
        chk("t3.g2.alu_ready", {63'd0, alu_ready}, 64'd1);
        step();
        alu_valid = 1'b0;
        chk_wr("t3.g3", 1'b1, 5'd11, 64'h82);
        chk("t3.g3.alu_ready", {63'd0, alu_ready}, 64'd0);
        step();
        chk_wr("t3.g4", 1'b1, 5'd9, 64'h62);
        chk("t3.g4.alu_ready", {63'd0, alu_ready}, 64'd1);
        step();
        chk_wr("t3.g5", 1'b1, 5'd10, 64'h63);
        step();
        chk("t3.g6.we", {63'd0, WriteReg}, 64'd0);
        chk("t3.g6.idle", {63'd0, idle}, 64'd1);

        // Reset, then two entries each: ALU, MEM, ALU, MEM back to back
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_wr("t2.rst", 1'b0, 5'd0, 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
        step();
        chk("t2.e0.we", {63'd0, WriteReg}, 64'd0);
        alu_rd = 5'd3; alu_data = 64'h33;
        mem_rd = 5'd4; mem_data = 64'h44;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk_wr("t2.e1", 1'b1, 5'd1, 64'h11);
        step();
        chk_wr("t2.e2", 1'b1, 5'd2, 64'h22);
        step();
        chk_wr("t2.e3", 1'b1, 5'd3, 64'h33);
        step();
        chk_wr("t2.e4", 1'b1, 5'd4, 64'h44);
        step();
        chk("t2.e5.we", {63'd0, WriteReg}, 64'd0);
        chk("t2.e5.idle", {63'd0, idle}, 64'd1);

        // x0 write: drained without enable, but last grant moves to ALU
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        step();
        alu_valid = 1'b0;
        chk("x0.h0.we", {63'd0, WriteReg}, 64'd0);
        step();
        chk("x0.h1.we", {63'd0, WriteReg}, 64'd0);
        chk("x0.h1.idle", {63'd0, idle}, 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC1;
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 64'hD1;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("x0.h2.we", {63'd0, WriteReg}, 64'd0);
        step();
        chk_wr("x0.h3", 1'b1, 5'd13, 64'hD1);
        step();
        chk_wr("x0.h4", 1'b1, 5'd12, 64'hC1);
        step();
        chk("x0.h5.idle", {63'd0, idle}, 64'd1);

        // Pending window for a load to r7
        ReadReg1 = 5'd7; ReadReg2 = 5'd0;
        #1;
        chk("pend.pre.p1", {63'd0, Pending1}, 64'd0);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
        step();
        mem_valid = 1'b0;
        chk("pend.p0.p1", {63'd0, Pending1}, {63'd0, pend_on});
        chk("pend.p0.p2", {63'd0, Pending2}, 64'd0);
        step();
        chk_wr("pend.p1", 1'b1, 5'd7, 64'h77);
        chk("pend.p1.p1", {63'd0, Pending1}, {63'd0, pend_on});
        chk("pend.p1.p2", {63'd0, Pending2}, 64'd0);
        step();
        chk("pend.p2.p1", {63'd0, Pending1}, 64'd0);
        chk("pend.p2.p2", {63'd0, Pending2}, 64'd0);
        ReadReg1 = 5'd0;

        // Reset with three entries queued and a write in the output register
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 64'hE1;
        mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 64'hF1;
        step();
        alu_rd = 5'd16; alu_data = 64'hE2;
        mem_rd = 5'd17; mem_data = 64'hF2;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk_wr("mrst.pre", 1'b1, 5'd14, 64'hE1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_wr("mrst.r", 1'b0, 5'd0, 64'd0);
        chk("mrst.idle", {63'd0, idle}, 64'd1);
        chk("mrst.alu_ready", {63'd0, alu_ready}, 64'd1);
        chk("mrst.mem_ready", {63'd0, mem_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst.after.we", {63'd0, WriteReg}, 64'd0);
            chk("mrst.after.idle", {63'd0, idle}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
